mem_wb_stage: RTL

Memory-access stage plus MEM/WB pipeline register for the five-stage MIPS pipeline. It consumes the EX/MEM register outputs, resolves the branch decision and performs the load or store against an internal word-addressed data RAM with configurable access latency. It stalls the upstream stages while an access is in flight, then registers the write-back bundle for the WB stage.

---
 rtl/mem_wb_stage.sv | 62 ++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage (branch resolve, latency-modelled data RAM, upstream stall) plus MEM/WB register
//   inputs : clk, rst_n (async, active-low), EX/MEM bundle wbM/memM/brnchDstM/zFlagM/alu_outM/rtM/wrDstM
//   outputs: pcSrc/brnchTgt/stall (combinational), wbW/rdDataW/alu_outW/wrDstW (registered)
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wbM,
  input  logic [2:0]  memM,
  input  logic [31:0] brnchDstM,
  input  logic        zFlagM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] rtM,
  input  logic [4:0]  wrDstM,
  output logic        pcSrc,
  output logic [31:0] brnchTgt,
  output logic        stall,
  output logic [1:0]  wbW,
  output logic [31:0] rdDataW,
  output logic [31:0] alu_outW,
  output logic [4:0]  wrDstW
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam bit HAS_LAT = (LAT != 0);
  state_t r_state;
  logic [3:0] r_cnt;
  logic [31:0] r_ram [0:(1 << ADDR_W) - 1];
  logic w_mem_op;
  logic w_stall;
  logic [ADDR_W-1:0] w_idx;
  assign w_mem_op = memM[1] | memM[0];
  assign w_idx    = alu_outM[ADDR_W+1:2];
  // not stalling is exactly the commit/capture condition
  assign w_stall  = (r_state == IDLE) ? (w_mem_op && HAS_LAT) : (r_cnt != 4'd0);
  assign stall    = rst_n & w_stall;
  assign pcSrc    = rst_n & memM[2] & zFlagM;
  assign brnchTgt = brnchDstM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      wbW      <= 2'b00;
      rdDataW  <= 32'd0;
      alu_outW <= 32'd0;
      wrDstW   <= 5'd0;
    end else begin
      r_state  <= w_stall ? BUSY : IDLE;
      r_cnt    <= (r_state == IDLE) ? (w_stall ? LAT_M1 : 4'd0) : (w_stall ? r_cnt - 4'd1 : 4'd0);
      wbW      <= w_stall ? 2'b00 : wbM;
      alu_outW <= w_stall ? alu_outW : alu_outM;
      wrDstW   <= w_stall ? wrDstW : wrDstM;
      rdDataW  <= (!w_stall && memM[1]) ? r_ram[w_idx] : rdDataW;
    end
  end
  // RAM is not reset; an edge seen while rst_n is low must not commit a pending store
  always_ff @(posedge clk) begin
    if (rst_n && !w_stall && memM[0]) r_ram[w_idx] <= rtM;
  end
endmodule
